// File: rtl/lock_manager_pkg.sv
// rtl/lock_manager_pkg.sv - shared OmpSsManager command/ack codes, field positions and lock FSM states
package lock_manager_pkg;

   // Command word field positions
   localparam int CMD_TYPE_L   = 0;
   localparam int CMD_TYPE_H   = 7;
   localparam int LOCK_ID_L    = 8;
   localparam int LOCK_ID_H    = 15;
   localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

   // Command codes understood by the lock manager
   localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
   localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;

   // Ack codes returned for LOCK commands
   localparam logic [7:0] ACK_OK_CODE     = 8'h01;
   localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

   // Source ID stamped on every ack leaving the lock manager
   localparam logic [4:0] HWR_LOCK_ID = 5'h15;

   // Lock manager control FSM
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ACK  = 2'd2
   } lock_state_t;

endpackage

// File: rtl/lock_table.sv
// rtl/lock_table.sv - registered owner/busy array with a single lookup/update port
module lock_table
   import lock_manager_pkg::*;
#(
   parameter int NUM_LOCKS = 16,
   parameter int ACC_BITS  = 6
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [$clog2(NUM_LOCKS)-1:0] i_idx,
   input  logic                         i_set,
   input  logic                         i_clr,
   input  logic [ACC_BITS-1:0]          i_owner,
   output logic                         o_busy,
   output logic [ACC_BITS-1:0]          o_owner,
   output logic [NUM_LOCKS-1:0]         o_busy_vec
);

   logic [NUM_LOCKS-1:0] r_busy;
   logic [ACC_BITS-1:0]  r_owner [NUM_LOCKS];

   // Lookup is combinational so the caller can decide and update in the same cycle
   assign o_busy     = r_busy[i_idx];
   assign o_owner    = r_owner[i_idx];
   assign o_busy_vec = r_busy;

   // Table update: set claims a slot for i_owner, clear releases it; set wins if both
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_busy <= '0;
         for (int i = 0; i < NUM_LOCKS; i++) begin
            r_owner[i] <= '0;
         end
      end else if (i_set) begin
         r_busy[i_idx]  <= 1'b1;
         r_owner[i_idx] <= i_owner;
      end else if (i_clr) begin
         r_busy[i_idx]  <= 1'b0;
         r_owner[i_idx] <= '0;
      end
   end

endmodule

// File: rtl/lock_manager.sv
// rtl/lock_manager.sv - hardware lock manager: LOCK/UNLOCK commands in, acks out
module lock_manager
   import lock_manager_pkg::*;
#(
   parameter int NUM_LOCKS = 16,
   parameter int ACC_BITS  = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 cmd_in_tvalid,
   output logic                 cmd_in_tready,
   input  logic [63:0]          cmd_in_tdata,
   input  logic [ACC_BITS-1:0]  cmd_in_tid,
   output logic                 ack_out_tvalid,
   input  logic                 ack_out_tready,
   output logic [63:0]          ack_out_tdata,
   output logic [ACC_BITS-1:0]  ack_out_tdest,
   output logic [4:0]           ack_out_tid,
   output logic [NUM_LOCKS-1:0] lock_busy,
   output logic                 cmd_err
);

   localparam int IDX_W = $clog2(NUM_LOCKS);

   lock_state_t r_state;
   lock_state_t w_state_next;

   logic [7:0]              r_cmd_code;
   logic [LOCK_ID_BITS-1:0] r_lock_id;
   logic [ACC_BITS-1:0]     r_tid;

   logic [7:0]              r_ack_code;
   logic [LOCK_ID_BITS-1:0] r_ack_id;
   logic [ACC_BITS-1:0]     r_ack_dest;

   logic                    w_accept;
   logic                    w_in_exec;
   logic                    w_is_lock;
   logic                    w_is_unlock;
   logic                    w_in_range;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_entry_busy;
   logic [ACC_BITS-1:0]     w_entry_owner;
   logic                    w_lock_ok;
   logic                    w_unlock_ok;
   logic                    w_tbl_set;
   logic                    w_tbl_clr;
   logic                    w_unused_tdata;

   // Only the code and lock ID fields carry meaning; the rest of the word is ignored
   assign w_unused_tdata = ^cmd_in_tdata[63:LOCK_ID_H+1];

   // Gating with rstn keeps the command port closed while reset is held
   assign cmd_in_tready = (r_state == IDLE) && rstn;
   assign w_accept      = cmd_in_tvalid && cmd_in_tready;
   assign w_in_exec     = (r_state == EXEC);

   // Decode of the registered command
   assign w_is_lock   = (r_cmd_code == CMD_LOCK_CODE);
   assign w_is_unlock = (r_cmd_code == CMD_UNLOCK_CODE);
   assign w_in_range  = ({1'b0, r_lock_id} < (LOCK_ID_BITS + 1)'(NUM_LOCKS));
   assign w_idx       = r_lock_id[IDX_W-1:0];

   // A lock is granted only when free; an unlock is honoured only from the owner
   assign w_lock_ok   = w_is_lock && w_in_range && !w_entry_busy;
   assign w_unlock_ok = w_is_unlock && w_in_range && w_entry_busy && (w_entry_owner == r_tid);
   assign w_tbl_set   = w_in_exec && w_lock_ok;
   assign w_tbl_clr   = w_in_exec && w_unlock_ok;

   // Out-of-range LOCK, refused UNLOCK and unknown codes all flag an error in EXEC
   assign cmd_err = w_in_exec &&
                    ((w_is_lock && !w_in_range) ||
                     (w_is_unlock && !w_unlock_ok) ||
                     (!w_is_lock && !w_is_unlock));

   assign ack_out_tvalid = (r_state == ACK);
   assign ack_out_tdata  = {{(64 - LOCK_ID_BITS - 8){1'b0}}, r_ack_id, r_ack_code};
   assign ack_out_tdest  = r_ack_dest;
   assign ack_out_tid    = HWR_LOCK_ID;

   lock_table #(
      .NUM_LOCKS (NUM_LOCKS),
      .ACC_BITS  (ACC_BITS)
   ) u_lock_table (
      .clk        (clk),
      .rstn       (rstn),
      .i_idx      (w_idx),
      .i_set      (w_tbl_set),
      .i_clr      (w_tbl_clr),
      .i_owner    (r_tid),
      .o_busy     (w_entry_busy),
      .o_owner    (w_entry_owner),
      .o_busy_vec (lock_busy)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: one command in flight; only LOCK produces an ack
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = EXEC;
         EXEC:    w_state_next = w_is_lock ? ACK : IDLE;
         ACK:     if (ack_out_tready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Capture the command fields and requester on the input handshake
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cmd_code <= '0;
         r_lock_id  <= '0;
         r_tid      <= '0;
      end else if (w_accept) begin
         r_cmd_code <= cmd_in_tdata[CMD_TYPE_H:CMD_TYPE_L];
         r_lock_id  <= cmd_in_tdata[LOCK_ID_H:LOCK_ID_L];
         r_tid      <= cmd_in_tid;
      end
   end

   // Build the ack in EXEC; it then stays stable for the whole ACK state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ack_code <= '0;
         r_ack_id   <= '0;
         r_ack_dest <= '0;
      end else if (w_in_exec && w_is_lock) begin
         r_ack_code <= w_lock_ok ? ACK_OK_CODE : ACK_REJECT_CODE;
         r_ack_id   <= r_lock_id;
         r_ack_dest <= r_tid;
      end
   end

endmodule

// File: tb/tb_lock_manager.sv
// tb/tb_lock_manager.sv - scoreboard bench for lock_manager
module tb_lock_manager;

   localparam int NUM_LOCKS = 16;
   localparam int ACC_BITS  = 6;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 cmd_in_tvalid;
   logic                 cmd_in_tready;
   logic [63:0]          cmd_in_tdata;
   logic [ACC_BITS-1:0]  cmd_in_tid;
   logic                 ack_out_tvalid;
   logic                 ack_out_tready;
   logic [63:0]          ack_out_tdata;
   logic [ACC_BITS-1:0]  ack_out_tdest;
   logic [4:0]           ack_out_tid;
   logic [NUM_LOCKS-1:0] lock_busy;
   logic                 cmd_err;

   typedef struct {
      logic [7:0]          code;
      logic [7:0]          id;
      logic [ACC_BITS-1:0] dest;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [63:0] held_data;

   always #5 clk = ~clk;

   lock_manager #(
      .NUM_LOCKS (NUM_LOCKS),
      .ACC_BITS  (ACC_BITS)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .cmd_in_tvalid  (cmd_in_tvalid),
      .cmd_in_tready  (cmd_in_tready),
      .cmd_in_tdata   (cmd_in_tdata),
      .cmd_in_tid     (cmd_in_tid),
      .ack_out_tvalid (ack_out_tvalid),
      .ack_out_tready (ack_out_tready),
      .ack_out_tdata  (ack_out_tdata),
      .ack_out_tdest  (ack_out_tdest),
      .ack_out_tid    (ack_out_tid),
      .lock_busy      (lock_busy),
      .cmd_err        (cmd_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ack handshake must match the oldest expected ack
   always @(negedge clk) begin
      if (rstn === 1'b1 && ack_out_tvalid === 1'b1 && ack_out_tready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("ack_tdata", ack_out_tdata, {48'h0, mon_e.id, mon_e.code});
            chk("ack_tdest", 64'(ack_out_tdest), 64'(mon_e.dest));
            chk("ack_tid", 64'(ack_out_tid), 64'h15);
         end
      end
   end

   // Present a command and return just after the posedge on which it was accepted
   task automatic send_cmd(input logic [7:0] code, input logic [7:0] id, input logic [ACC_BITS-1:0] tid);
      bit ok = 0;
      @(posedge clk) #1;
      cmd_in_tvalid = 1'b1;
      cmd_in_tdata  = {48'h0, id, code};
      cmd_in_tid    = tid;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_in_tready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
      @(posedge clk) #1;
      cmd_in_tvalid = 1'b0;
   endtask

   // Check cmd_err in EXEC (T+1) and ack/busy at T+2
   task automatic post_checks(input string tag, input logic err, input logic ackv, input logic [15:0] busy);
      @(negedge clk);
      chk({tag, "_cmd_err"}, 64'(cmd_err), 64'(err));
      @(negedge clk);
      chk({tag, "_ack_valid"}, 64'(ack_out_tvalid), 64'(ackv));
      chk({tag, "_lock_busy"}, 64'(lock_busy), 64'(busy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn           = 1'b0;
      cmd_in_tvalid  = 1'b0;
      cmd_in_tdata   = '0;
      cmd_in_tid     = '0;
      ack_out_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_tready", 64'(cmd_in_tready), 64'd0);
      chk("rst_ack_tvalid", 64'(ack_out_tvalid), 64'd0);
      chk("rst_lock_busy", 64'(lock_busy), 64'd0);
      chk("rst_cmd_err", 64'(cmd_err), 64'd0);
      chk("rst_ack_tdata", ack_out_tdata, 64'd0);
      chk("rst_ack_tdest", 64'(ack_out_tdest), 64'd0);
      @(posedge clk) #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_tready", 64'(cmd_in_tready), 64'd1);

      // LOCK 3 from 5 on an idle table
      sb.push_back('{code: 8'h01, id: 8'd3, dest: 6'd5});
      send_cmd(8'h04, 8'd3, 6'd5);
      post_checks("lock3_t5", 1'b0, 1'b1, 16'h0008);

      // LOCK 3 from 7 while held by 5
      sb.push_back('{code: 8'h00, id: 8'd3, dest: 6'd7});
      send_cmd(8'h04, 8'd3, 6'd7);
      post_checks("lock3_t7", 1'b0, 1'b1, 16'h0008);

      // UNLOCK 3 from non-owner 7
      send_cmd(8'h06, 8'd3, 6'd7);
      post_checks("unlock3_t7", 1'b1, 1'b0, 16'h0008);

      // UNLOCK 3 from owner 5, back in IDLE at T+2
      send_cmd(8'h06, 8'd3, 6'd5);
      post_checks("unlock3_t5", 1'b0, 1'b0, 16'h0000);
      chk("unlock3_t5_idle", 64'(cmd_in_tready), 64'd1);

      // LOCK out of range
      sb.push_back('{code: 8'h00, id: 8'd20, dest: 6'd2});
      send_cmd(8'h04, 8'd20, 6'd2);
      post_checks("lock20", 1'b1, 1'b1, 16'h0000);

      // Unknown command code
      send_cmd(8'h09, 8'd1, 6'd1);
      post_checks("bad_code", 1'b1, 1'b0, 16'h0000);

      // Highest slot, first out-of-range slot, unlock of a free slot
      sb.push_back('{code: 8'h01, id: 8'd15, dest: 6'd63});
      send_cmd(8'h04, 8'd15, 6'd63);
      post_checks("lock15", 1'b0, 1'b1, 16'h8000);
      sb.push_back('{code: 8'h00, id: 8'd16, dest: 6'd63});
      send_cmd(8'h04, 8'd16, 6'd63);
      post_checks("lock16", 1'b1, 1'b1, 16'h8000);
      send_cmd(8'h06, 8'd2, 6'd63);
      post_checks("unlock_free", 1'b1, 1'b0, 16'h8000);
      send_cmd(8'h06, 8'd15, 6'd63);
      post_checks("unlock15", 1'b0, 1'b0, 16'h0000);

      // Ack stall for 10 cycles with a command waiting
      ack_out_tready = 1'b0;
      sb.push_back('{code: 8'h01, id: 8'd5, dest: 6'd9});
      send_cmd(8'h04, 8'd5, 6'd9);
      post_checks("stall_lock5", 1'b0, 1'b1, 16'h0020);
      held_data = ack_out_tdata;
      chk("stall_data_init", held_data, 64'h0000_0000_0000_0501);
      cmd_in_tvalid = 1'b1;
      cmd_in_tdata  = {48'h0, 8'd5, 8'h06};
      cmd_in_tid    = 6'd9;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_tvalid", 64'(ack_out_tvalid), 64'd1);
         chk("stall_tdata", ack_out_tdata, held_data);
         chk("stall_tdest", 64'(ack_out_tdest), 64'd9);
         chk("stall_cmd_tready", 64'(cmd_in_tready), 64'd0);
         chk("stall_busy", 64'(lock_busy), 64'h0020);
      end
      @(posedge clk) #1;
      ack_out_tready = 1'b1;
      @(negedge clk);
      chk("stall_hs_cmd_tready", 64'(cmd_in_tready), 64'd0);
      @(negedge clk);
      chk("stall_next_accept", 64'(cmd_in_tready), 64'd1);
      @(posedge clk) #1;
      cmd_in_tvalid = 1'b0;
      post_checks("stall_unlock5", 1'b0, 1'b0, 16'h0000);

      // Reset while an ack is pending: it must never be emitted
      ack_out_tready = 1'b0;
      send_cmd(8'h04, 8'd7, 6'd4);
      post_checks("rstack_lock7", 1'b0, 1'b1, 16'h0080);
      @(posedge clk) #1;
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstack_tvalid", 64'(ack_out_tvalid), 64'd0);
      chk("rstack_busy", 64'(lock_busy), 64'd0);
      chk("rstack_tready_low", 64'(cmd_in_tready), 64'd0);
      @(posedge clk) #1;
      rstn = 1'b1;
      ack_out_tready = 1'b1;
      @(negedge clk);
      chk("rstack_tready", 64'(cmd_in_tready), 64'd1);
      chk("rstack_no_ack", 64'(ack_out_tvalid), 64'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
